seg7_scan_decoder: RTL

//  Receive-side counterpart of the multiplexed 8-digit seven-segment driver. Samples
//  the active-low anode/cathode scan lines and decodes each cathode pattern back to a
//  hex nibble. Publishes a coherent 8-digit frame once every digit has been observed.

---
 rtl/seg7_scan_if.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_if
// Brief    : Scan-line inputs and decoded-frame outputs of the 7-seg scan decoder.
// Revision : 1.0
// ============================================================================
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic                  dec_en;
  logic [6:0]            dec_cc;
  logic [DIGITS-1:0]     dec_an;
  logic [4*DIGITS-1:0]   dec_digits;
  logic [DIGITS-1:0]     dec_blank;
  logic                  dec_frame_stb;
  logic                  dec_frame_valid;
  logic                  dec_err;

  modport master (
    output dec_en, dec_cc, dec_an,
    input  dec_digits, dec_blank, dec_frame_stb, dec_frame_valid, dec_err
  );

  modport slave (
    input  dec_en, dec_cc, dec_an,
    output dec_digits, dec_blank, dec_frame_stb, dec_frame_valid, dec_err
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Samples active-low 7-seg scan lines, decodes digits, publishes frames.
// Revision : 1.0
// ============================================================================
module seg7_scan_decoder #(
  parameter int DIGITS  = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic       sys_clk,
  input  logic       dec_rst,
  seg7_scan_if.slave bus
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0]     C_SETTLE  = SW'(SETTLE);
  localparam logic [TW-1:0]     C_TIMEOUT = TW'(TIMEOUT);
  localparam logic [TW-1:0]     C_TMO_M1  = TW'(TIMEOUT - 1);
  localparam logic [DIGITS-1:0] C_ONE     = DIGITS'(1);

  typedef enum logic [0:0] {
    SETTLING = 1'b0,
    HOLD     = 1'b1
  } state_t;

  state_t                 r_state;
  logic [6:0]             r_cc;
  logic [DIGITS-1:0]      r_an;
  logic [SW-1:0]          r_settle;
  logic [TW-1:0]          r_tmo;
  logic [DIGITS-1:0]      r_seen;
  logic [DIGITS-1:0][3:0] r_shadow;
  logic [DIGITS-1:0]      r_shadow_blank;
  logic [4*DIGITS-1:0]    r_digits;
  logic [DIGITS-1:0]      r_blank;
  logic                   r_stb;
  logic                   r_valid;
  logic                   r_err;

  logic [DIGITS-1:0]      w_an_low;
  logic                   w_any;
  logic                   w_multi;
  logic [IW-1:0]          w_idx;
  logic [3:0]             w_nib;
  logic                   w_legal;
  logic                   w_is_blank;
  logic                   w_changing;
  logic                   w_eval;
  logic                   w_capture;
  logic [DIGITS-1:0]      w_cap_mask;
  logic                   w_all_seen;

  assign w_an_low   = ~r_an;
  assign w_any      = |w_an_low;
  assign w_multi    = (w_an_low & (w_an_low - C_ONE)) != '0;
  // Compares the value about to be registered, so the counter restarts on the edge R changes.
  assign w_changing = (bus.dec_cc != r_cc) || (bus.dec_an != r_an);
  assign w_eval     = bus.dec_en && (r_state == SETTLING) && (r_settle == C_SETTLE);
  assign w_capture  = w_eval && w_any && !w_multi;
  assign w_cap_mask = w_capture ? (C_ONE << w_idx) : '0;
  assign w_all_seen = (r_seen == '1);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_an_low[i]) w_idx = IW'(i);
    end
  end

  always_comb begin
    w_nib      = 4'h0;
    w_legal    = 1'b1;
    w_is_blank = 1'b0;
    case (r_cc)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_is_blank = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (dec_rst) begin
      r_state        <= SETTLING;
      r_cc           <= '1;
      r_an           <= '1;
      r_settle       <= '0;
      r_tmo          <= '0;
      r_seen         <= '0;
      r_shadow       <= '0;
      r_shadow_blank <= '1;
      r_digits       <= '0;
      r_blank        <= '1;
      r_stb          <= 1'b0;
      r_valid        <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_cc  <= bus.dec_cc;
      r_an  <= bus.dec_an;
      r_stb <= 1'b0;
      r_err <= 1'b0;
      if (!bus.dec_en) begin
        r_state  <= SETTLING;
        r_settle <= '0;
        r_seen   <= '0;
      end else begin
        if (w_changing)
          r_settle <= '0;
        else if (r_settle != C_SETTLE)
          r_settle <= r_settle + SW'(1);

        case (r_state)
          SETTLING: if (r_settle == C_SETTLE) r_state <= HOLD;
          HOLD:     if (r_settle != C_SETTLE) r_state <= SETTLING;
          default:  r_state <= SETTLING;
        endcase

        if (w_eval && (w_multi || (w_any && !w_legal)))
          r_err <= 1'b1;

        if (w_capture) begin
          r_shadow[w_idx]       <= w_legal ? w_nib : 4'h0;
          r_shadow_blank[w_idx] <= w_is_blank || !w_legal;
        end

        // Publish uses the pre-update shadow; a same-cycle capture belongs to the next frame.
        if (w_all_seen) begin
          r_digits <= r_shadow;
          r_blank  <= r_shadow_blank;
          r_stb    <= 1'b1;
          r_valid  <= 1'b1;
          r_seen   <= w_cap_mask;
          r_tmo    <= '0;
        end else begin
          r_seen <= r_seen | w_cap_mask;
          if (w_capture) begin
            r_tmo <= '0;
          end else if (r_tmo != C_TIMEOUT) begin
            r_tmo <= r_tmo + TW'(1);
            if (r_tmo == C_TMO_M1) r_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.dec_digits      = r_digits;
  assign bus.dec_blank       = r_blank;
  assign bus.dec_frame_stb   = r_stb;
  assign bus.dec_frame_valid = r_valid;
  assign bus.dec_err         = r_err;
endmodule
`default_nettype wire
